// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned AW_DEF     = 16;
    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned PC_INC_DEF = 1;

    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_out_reg.sv
// One-entry output register holding the fetched word and its address for decode.
module if_out_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] d_instr,
    input  logic [AW-1:0] d_pc,
    output logic          valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc
);

    // Load captures a new word; clear only drops valid so the payload stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= AW'(RESET_PC);
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: requests the word at pc, buffers it for decode, steers the pc.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned PC_INC = PC_INC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_cur,
    output logic [AW-1:0] pc_nxt,
    output logic          pc_wrt_s2,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          if_valid,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          id_ready
);

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [AW-1:0] addr_q;
    logic          out_load;
    logic          out_clear;
    logic          addr_load;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pc steering and output-register controls; redirect outranks everything.
    always_comb begin
        state_nxt = state;
        pc_wrt_s2 = 1'b0;
        pc_nxt    = '0;
        out_load  = 1'b0;
        out_clear = 1'b0;
        addr_load = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_wrt_s2 = 1'b1;
                    pc_nxt    = redirect_pc;
                    if (imem_ack) begin
                        state_nxt = ST_REQ;
                    end else begin
                        addr_load = 1'b1;
                        state_nxt = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_wrt_s2 = 1'b1;
                    pc_nxt    = pc_cur + AW'(PC_INC);
                    out_load  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_wrt_s2 = 1'b1;
                    pc_nxt    = redirect_pc;
                    out_clear = 1'b1;
                    state_nxt = ST_REQ;
                end else if (id_ready) begin
                    out_clear = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_wrt_s2 = 1'b1;
                    pc_nxt    = redirect_pc;
                end else if (imem_ack) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Memory request port; the address only moves when a new request begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req  <= 1'b0;
            imem_addr <= AW'(RESET_PC);
            addr_q    <= AW'(RESET_PC);
        end else begin
            imem_req <= (state_nxt == ST_REQ) || (state_nxt == ST_DRAIN);
            if (addr_load) begin
                addr_q <= pc_cur;
            end
            if ((state_nxt == ST_REQ) && ((state != ST_REQ) || pc_wrt_s2)) begin
                // A pc write this cycle lands in pc_cur only after the edge, so forward it.
                imem_addr <= pc_wrt_s2 ? pc_nxt : pc_cur;
            end else if (state_nxt == ST_DRAIN) begin
                imem_addr <= addr_load ? pc_cur : addr_q;
            end
        end
    end

    if_out_reg #(
        .AW (AW),
        .DW (DW)
    ) u_if_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (out_load),
        .clear   (out_clear),
        .d_instr (imem_rdata),
        .d_pc    (pc_cur),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: pc register and memory environment, program-order model, directed tests.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] pc_cur;
    logic [15:0] pc_nxt;
    logic        pc_wrt_s2;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'hDEAD;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_cur      (pc_cur),
        .pc_nxt      (pc_nxt),
        .pc_wrt_s2   (pc_wrt_s2),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Environment pc register (not reset, so a restart fetches from whatever pc holds).
    logic [15:0] pc_reg = 16'h0000;
    logic        pc_force = 1'b0;
    logic [15:0] pc_force_val = 16'h0000;
    assign pc_cur = pc_reg;

    always @(posedge clk) begin
        if (pc_force) pc_reg <= pc_force_val;
        else if (pc_wrt_s2) pc_reg <= pc_nxt;
    end

    // Memory responder: acks once a request has been up for mem_lat cycles.
    int   mem_lat  = 0;
    int   wait_cnt = 0;
    logic last_req = 1'b0;
    logic last_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) wait_cnt = 0;
        else if (last_req && last_ack) wait_cnt = 0;
        else if (last_req) wait_cnt++;
        imem_ack   = imem_req && (wait_cnt >= mem_lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 16'hDEAD;
    end

    // Model: words reach decode in program order, one cycle after the ack that fetched them;
    // a redirect restarts the order and any in-flight unacked request is completed and dropped.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        int          cyc;
    } deliv_t;

    deliv_t      dq[$];
    deliv_t      d;
    int          cyc = 0;
    logic [15:0] exp_fetch = 16'h0000;
    logic        stale = 1'b0;
    logic [15:0] stale_addr = 16'h0000;
    logic        p_valid = 1'b0;
    logic        p_take = 1'b0;
    logic        p_redir = 1'b0;
    logic [15:0] p_pc = 16'h0000;
    logic [15:0] p_instr = 16'h0000;
    logic        rise;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk1("m_rst_if_valid", if_valid, 1'b0);
            chk1("m_rst_imem_req", imem_req, 1'b0);
            chk1("m_rst_pc_wrt", pc_wrt_s2, 1'b0);
            chk16("m_rst_pc_nxt", pc_nxt, 16'h0000);
            dq.delete();
            stale     = 1'b0;
            exp_fetch = pc_reg;
            p_valid   = 1'b0;
            p_take    = 1'b0;
            p_redir   = 1'b0;
            last_req  = 1'b0;
            last_ack  = 1'b0;
        end else begin
            if (pc_force) exp_fetch = pc_force_val;
            rise = if_valid && !p_valid;
            if (rise || (dq.size() > 0 && cyc > dq[0].cyc)) begin
                if (dq.size() == 0) begin
                    chk1("m_unexpected_word", if_valid, 1'b0);
                end else begin
                    d = dq.pop_front();
                    chk1("m_deliver_valid", if_valid, 1'b1);
                    chki("m_deliver_latency", cyc - d.cyc, 1);
                    chk16("m_deliver_pc", if_pc, d.pc);
                    chk16("m_deliver_instr", if_instr, d.instr);
                end
            end
            if (p_valid) begin
                if (p_take || p_redir) begin
                    chk1("m_valid_clear", if_valid, 1'b0);
                end else begin
                    chk1("m_valid_hold", if_valid, 1'b1);
                    chk16("m_pc_hold", if_pc, p_pc);
                    chk16("m_instr_hold", if_instr, p_instr);
                end
            end
            if (if_valid) chk1("m_no_req_while_valid", imem_req, 1'b0);
            if (imem_req) chk16("m_imem_addr", imem_addr, stale ? stale_addr : exp_fetch);
            if (redirect) begin
                chk1("m_redir_wrt", pc_wrt_s2, 1'b1);
                chk16("m_redir_pc_nxt", pc_nxt, redirect_pc);
                if (imem_req && !imem_ack && !stale) begin
                    stale      = 1'b1;
                    stale_addr = exp_fetch;
                end
                exp_fetch = redirect_pc;
            end else if (imem_req && imem_ack && !stale) begin
                chk1("m_seq_wrt", pc_wrt_s2, 1'b1);
                chk16("m_seq_pc_nxt", pc_nxt, 16'(exp_fetch + 16'd1));
                dq.push_back('{pc: exp_fetch, instr: mem_word(exp_fetch), cyc: cyc});
                exp_fetch = 16'(exp_fetch + 16'd1);
            end else begin
                chk1("m_no_wrt", pc_wrt_s2, 1'b0);
                if (imem_req && imem_ack) stale = 1'b0;
            end
            p_valid  = if_valid;
            p_take   = if_valid && id_ready;
            p_redir  = redirect;
            p_pc     = if_pc;
            p_instr  = if_instr;
            last_req = imem_req;
            last_ack = imem_ack;
        end
    end

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(imem_req && imem_ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!(imem_req && imem_ack)) begin
            n_fail++;
            $display("FAIL %s: no acked request within 20 cycles", name);
        end
    endtask

    logic [15:0] t1_instr [3] = '{16'hC3A5, 16'hC2A5, 16'hC1A5};

    // Directed scenarios with literal expectations.
    initial begin
        #1 rst_n = 1'b0;
        id_ready = 1'b1;
        mem_lat  = 0;
        repeat (2) @(negedge clk);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk16("rst_if_instr", if_instr, 16'h0000);
        chk16("rst_if_pc", if_pc, 16'h0000);
        chk16("rst_imem_addr", imem_addr, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: back-to-back sequential fetches.
        for (int k = 0; k < 3; k++) begin
            wait_ack("t1_ack");
            chk16("t1_imem_addr", imem_addr, 16'(k));
            chk1("t1_pc_wrt", pc_wrt_s2, 1'b1);
            chk16("t1_pc_nxt", pc_nxt, 16'(k + 1));
            if (k == 2) begin
                @(posedge clk);
                #1 id_ready = 1'b0;
            end
            @(negedge clk);
            chk1("t1_if_valid", if_valid, 1'b1);
            chk16("t1_if_pc", if_pc, 16'(k));
            chk16("t1_if_instr", if_instr, t1_instr[k]);
        end

        // T2: decode stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            chk1("t2_if_valid", if_valid, 1'b1);
            chk16("t2_if_pc", if_pc, 16'h0002);
            chk16("t2_if_instr", if_instr, 16'hC1A5);
            chk1("t2_imem_req", imem_req, 1'b0);
            chk1("t2_pc_wrt", pc_wrt_s2, 1'b0);
            if (i < 4) @(negedge clk);
        end

        // T3: pc wraps from 0xFFFF.
        @(posedge clk);
        #1 pc_force = 1'b1;
        pc_force_val = 16'hFFFF;
        @(posedge clk);
        #1 pc_force = 1'b0;
        id_ready = 1'b1;
        wait_ack("t3_ack");
        chk16("t3_imem_addr", imem_addr, 16'hFFFF);
        chk1("t3_pc_wrt", pc_wrt_s2, 1'b1);
        chk16("t3_pc_nxt", pc_nxt, 16'h0000);
        mem_lat = 3;
        @(negedge clk);
        chk1("t3_if_valid", if_valid, 1'b1);
        chk16("t3_if_pc", if_pc, 16'hFFFF);
        chk16("t3_if_instr", if_instr, 16'h3C5A);

        // T4: redirect while a slow request is outstanding.
        @(negedge clk);
        chk1("t4_req", imem_req, 1'b1);
        chk16("t4_addr", imem_addr, 16'h0000);
        chk1("t4_no_ack", imem_ack, 1'b0);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        chk1("t4_redir_wrt", pc_wrt_s2, 1'b1);
        chk16("t4_redir_nxt", pc_nxt, 16'h0040);
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk1("t4_drain_req", imem_req, 1'b1);
        chk16("t4_drain_addr", imem_addr, 16'h0000);
        chk1("t4_drain_wrt", pc_wrt_s2, 1'b0);
        @(negedge clk);
        chk1("t4_drain_ack", imem_ack, 1'b1);
        chk16("t4_drain_ack_addr", imem_addr, 16'h0000);
        chk1("t4_drain_ack_wrt", pc_wrt_s2, 1'b0);
        mem_lat = 0;
        @(negedge clk);
        chk16("t4_new_addr", imem_addr, 16'h0040);
        chk1("t4_no_stale_valid", if_valid, 1'b0);
        chk16("t4_new_pc_nxt", pc_nxt, 16'h0041);

        // T5: redirect squashes the word sitting in HOLD.
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        chk1("t5_if_valid", if_valid, 1'b1);
        chk16("t5_if_pc", if_pc, 16'h0040);
        chk1("t5_wrt", pc_wrt_s2, 1'b1);
        chk16("t5_nxt", pc_nxt, 16'h0100);
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk1("t5_squashed", if_valid, 1'b0);
        chk1("t5_req", imem_req, 1'b1);
        chk16("t5_addr", imem_addr, 16'h0100);
        @(negedge clk);
        chk16("t5_if_pc2", if_pc, 16'h0100);
        chk16("t5_if_instr2", if_instr, 16'hC3A4);
        mem_lat = 5;

        // T6: reset in the middle of a drain.
        @(negedge clk);
        chk16("t6_req_addr", imem_addr, 16'h0101);
        chk1("t6_no_ack", imem_ack, 1'b0);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 16'h0200;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk1("t6_drain_req", imem_req, 1'b1);
        chk16("t6_drain_addr", imem_addr, 16'h0101);
        #2 rst_n = 1'b0;
        mem_lat = 0;
        #1;
        chk1("t6_async_valid", if_valid, 1'b0);
        chk16("t6_async_instr", if_instr, 16'h0000);
        chk16("t6_async_pc", if_pc, 16'h0000);
        chk1("t6_async_req", imem_req, 1'b0);
        chk16("t6_async_addr", imem_addr, 16'h0000);
        chk1("t6_async_wrt", pc_wrt_s2, 1'b0);
        chk16("t6_async_nxt", pc_nxt, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ack("t6_ack");
        chk16("t6_restart_addr", imem_addr, 16'h0200);
        @(negedge clk);
        chk16("t6_restart_if_pc", if_pc, 16'h0200);
        chk16("t6_restart_instr", if_instr, 16'hC3A7);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
